uart_prog_loader: RTL and testbench
===================================

// Module: uart_prog_loader
// PURPOSE
//  SoC-side UART program loader: receives 8N1 bytes on uart_rx_i, packs every 4 bytes
//  LSB-first into a 32-bit instruction word and writes it to instruction memory at
//  incrementing word addresses. Asserts boot_done_o after the last word so core reset
//  can be released. Sits between the SoC uart_rx_i pad and the instruction RAM write port.
// PARAMETERS
//  CLKS_PER_BIT  87     clk_i cycles per UART bit (10 MHz / 115200 + 1)
//  MEM_AW        12     instruction memory word-address width
//  MAX_WORDS     4096   load terminates after this many words
//  TIMEOUT_CYC   1740   idle-line cycles (20 bit times) that end a load
// PORTS
//  clk_i        in   1       system clock
//  rst_ni       in   1       synchronous, active-low reset
//  uart_rx_i    in   1       UART serial input, idle high
//  mem_req_o    out  1       write request
//  mem_we_o     out  1       write enable, equals mem_req_o
//  mem_addr_o   out  MEM_AW  word address
//  mem_wdata_o  out  32      write data
//  mem_be_o     out  4       byte enables
//  mem_gnt_i    in   1       grant; write completes in the cycle req&gnt
//  boot_done_o  out  1       load finished, sticky until reset
//  word_cnt_o   out  MEM_AW+1 words written
//  frame_err_o  out  1       sticky: stop bit sampled low
//  overrun_o    out  1       sticky: word dropped, previous write still pending
//  csum_o       out  32      checksum (see CONFIGURATION)
// BEHAVIOUR
//  Reset values: all outputs 0. Internal 2-flop rx synchronizer resets to 1.
//  Reset sampled mid-byte or mid-write: everything returns to reset next edge; req drops.
//  RX FSM (IDLE,START,DATA,STOP):
//   IDLE->START on synced falling edge.
//   START: wait CLKS_PER_BIT/2; sample 0 -> DATA, else glitch -> IDLE (no error).
//   DATA: sample every CLKS_PER_BIT; 8 bits, LSB first.
//   STOP: sample after CLKS_PER_BIT.
//    1 -> byte valid (1-cycle strobe), IDLE.
//    0 -> byte discarded, frame_err_o=1, wait for line high, IDLE.
//  Packing: byte k (k=0..3) lands in word[8k+7:8k]; 4th byte completes word -> hold buffer.
//  Write port: req/addr/data/be stable from word completion until req&gnt.
//   Addr increments and word_cnt_o increments in the grant cycle; first addr is 0.
//   Word completing while buffer still pending: new word dropped, overrun_o=1, addr unchanged.
//  Loader FSM (LOAD,WRITE,DONE):
//   LOAD->WRITE on word complete; WRITE->LOAD on grant.
//   DONE when word_cnt_o==MAX_WORDS, or when line idle TIMEOUT_CYC cycles with
//   word_cnt_o>0 or a partial word pending. Idle counter clears on any rx low.
//   Partial word at timeout: missing bytes 0, mem_be_o only received bytes, then DONE.
//   DONE: boot_done_o=1, uart_rx_i ignored, no further requests.
//   Timeout with nothing received: stays LOAD.
//  Latency: stop-bit sample -> mem_req_o = 1 cycle (4th byte).
//   Last grant -> boot_done_o = 1 cycle (MAX_WORDS case).
// CONFIGURATION
//  UART_PROG_LOADER_CSUM_EN defined:
//   csum_o = 32-bit wraparound sum of granted words (partial word as written).
//   Updated in grant cycle.
//  Undefined: csum_o tied 0, no adder.
// STRUCTURE
//  Package uart_prog_loader_pkg:
//   rx_state_e, ld_state_e enums; BYTES_PER_WORD=4; half-bit constant function.
//  Sub-module uart_rx_byte: synchronizer + RX FSM.
//   Outputs byte_o[7:0], byte_valid_o, frame_err_o, line_idle_o.
//  Top: packing, hold buffer, loader FSM, counters.
// TESTING
//  1. Bytes 13 01 20 00, gnt=1 -> one write addr 0, data 0x00200113, be 4'hF, word_cnt_o=1.
//  2. 3 words then idle -> boot_done_o high TIMEOUT_CYC cycles after last stop bit, word_cnt_o=3.
//     With CSUM_EN, csum_o = sum of the 3 words.
//  3. Byte with stop bit 0, then AA BB CC DD -> frame_err_o=1; one write, data 0xDDCCBBAA.
//  4. gnt held 0 across 2 words -> overrun_o=1; after gnt, one write at addr 0; word_cnt_o=1.
//  5. 6 bytes AA..FF then idle -> writes 0xDDCCBBAA (be F), 0x0000FFEE (be 4'b0011); done.
//  6. rx low 20 cycles (glitch) -> no byte, no error.
//     rst_ni low mid-byte -> all outputs 0; next byte received correctly.

Source files
------------

// File: rtl/uart_prog_loader_pkg.sv
// Shared types and helpers for the UART program loader.
// Holds the RX and loader state encodings, word geometry and small constant helpers.
package uart_prog_loader_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        LD_LOAD,
        LD_WRITE,
        LD_DONE
    } ld_state_e;

    localparam int BYTES_PER_WORD = 4;

    function automatic int half_bit(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

    // Byte-enable mask covering the lowest n bytes of a word.
    function automatic logic [3:0] be_mask(input logic [1:0] n);
        logic [4:0] m;
        m = (5'd1 << n) - 5'd1;
        return m[3:0];
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, falling-edge start detect, mid-bit sampling.
// Emits single-cycle byte_valid_o / frame_err_o strobes in the stop-bit sample cycle.
module uart_rx_byte
    import uart_prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o,
    output logic       line_idle_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(half_bit(CLKS_PER_BIT) - 1);

    logic [1:0]       sync;
    logic             rx_s;
    logic             rx_prev;
    rx_state_e        state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       bit_idx, bit_next;
    logic [7:0]       shreg, shreg_next;

    assign rx_s        = sync[1];
    assign line_idle_o = rx_s;
    assign byte_o      = shreg;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync    <= 2'b11;
            rx_prev <= 1'b1;
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            sync    <= {sync[0], rx_i};
            rx_prev <= rx_s;
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_next;
            shreg   <= shreg_next;
        end
    end

    // A frame error leaves rx_prev low, so no new start is seen until the line returns high.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt + 1'b1;
        bit_next     = bit_idx;
        shreg_next   = shreg;
        byte_valid_o = 1'b0;
        frame_err_o  = 1'b0;
        unique case (state)
            RX_IDLE: begin
                cnt_next = '0;
                if (rx_prev && !rx_s) state_next = RX_START;
            end
            RX_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == FULL_LAST) begin
                    cnt_next   = '0;
                    shreg_next = {rx_s, shreg[7:1]};
                    bit_next   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == FULL_LAST) begin
                    cnt_next     = '0;
                    state_next   = RX_IDLE;
                    byte_valid_o = rx_s;
                    frame_err_o  = !rx_s;
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_prog_loader.sv
// UART program loader: packs received bytes LSB-first into 32-bit words and writes them to
// instruction memory. Optional checksum of granted words under UART_PROG_LOADER_CSUM_EN.
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int MEM_AW       = 12,
    parameter int MAX_WORDS    = 4096,
    parameter int TIMEOUT_CYC  = 1740
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              uart_rx_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_be_o,
    input  logic              mem_gnt_i,
    output logic              boot_done_o,
    output logic [MEM_AW:0]   word_cnt_o,
    output logic              frame_err_o,
    output logic              overrun_o,
    output logic [31:0]       csum_o
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDLE_W-1:0] TIMEOUT_V = IDLE_W'(TIMEOUT_CYC);
    localparam logic [MEM_AW:0]   LAST_CNT  = (MEM_AW + 1)'(MAX_WORDS - 1);

    logic [7:0]        rx_byte;
    logic              rx_valid;
    logic              rx_ferr;
    logic              line_idle;
    ld_state_e         state, state_next;
    logic [31:0]       acc;
    logic [1:0]        byte_idx;
    logic [IDLE_W-1:0] idle_cnt;
    logic              final_word;
    logic              word_done;
    logic              partial;
    logic              timeout;
    logic              flush;
    logic              grant;
    logic              last_grant;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .rx_i        (uart_rx_i),
        .byte_o      (rx_byte),
        .byte_valid_o(rx_valid),
        .frame_err_o (rx_ferr),
        .line_idle_o (line_idle)
    );

    assign word_done  = rx_valid && (byte_idx == 2'(BYTES_PER_WORD - 1));
    assign partial    = (byte_idx != 2'd0);
    assign timeout    = (idle_cnt == TIMEOUT_V);
    assign flush      = (state == LD_LOAD) && timeout && partial && !rx_valid;
    assign grant      = (state == LD_WRITE) && mem_gnt_i;
    assign last_grant = grant && (final_word || (word_cnt_o == LAST_CNT));

    assign mem_req_o   = (state == LD_WRITE);
    assign mem_we_o    = mem_req_o;
    assign boot_done_o = (state == LD_DONE);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state <= LD_LOAD;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            LD_LOAD: begin
                if (word_done || flush)                   state_next = LD_WRITE;
                else if (timeout && word_cnt_o != '0)     state_next = LD_DONE;
            end
            LD_WRITE: begin
                if (grant) state_next = last_grant ? LD_DONE : LD_LOAD;
            end
            LD_DONE:  state_next = LD_DONE;
            default:  state_next = LD_LOAD;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc         <= '0;
            byte_idx    <= '0;
            idle_cnt    <= '0;
            final_word  <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_be_o    <= '0;
            word_cnt_o  <= '0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            if (state != LD_DONE) begin
                if (!line_idle)    idle_cnt <= '0;
                else if (!timeout) idle_cnt <= idle_cnt + 1'b1;
                if (rx_ferr) frame_err_o <= 1'b1;
                if (rx_valid) begin
                    if (word_done) begin
                        acc      <= '0;
                        byte_idx <= '0;
                    end else begin
                        acc[{byte_idx, 3'b000} +: 8] <= rx_byte;
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
            end
            // The hold buffer only loads from LOAD; a word finishing during WRITE is lost.
            if (state == LD_LOAD && word_done) begin
                mem_wdata_o <= {rx_byte, acc[23:0]};
                mem_be_o    <= 4'hF;
            end else if (flush) begin
                mem_wdata_o <= acc;
                mem_be_o    <= be_mask(byte_idx);
                acc         <= '0;
                byte_idx    <= '0;
                final_word  <= 1'b1;
            end
            if (state == LD_WRITE && word_done) overrun_o <= 1'b1;
            if (grant) begin
                mem_addr_o <= mem_addr_o + 1'b1;
                word_cnt_o <= word_cnt_o + 1'b1;
            end
        end
    end

`ifdef UART_PROG_LOADER_CSUM_EN
    logic [31:0] csum;

    always_ff @(posedge clk_i) begin
        if (!rst_ni)    csum <= '0;
        else if (grant) csum <= csum + mem_wdata_o;
    end

    assign csum_o = csum;
`else
    assign csum_o = '0;
`endif

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: expected writes are queued as bytes are driven
// and checked against each granted memory write.
module tb_uart_prog_loader;

    localparam int CPB  = 50;
    localparam int AW   = 12;
    localparam int MAXW = 4;
    localparam int TO   = 20 * CPB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx = 1'b1;
    logic          gnt = 1'b0;
    logic          req, we, done, ferr, ovr;
    logic [AW-1:0] addr;
    logic [31:0]   wdata, csum;
    logic [3:0]    be;
    logic [AW:0]   wcnt;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
        logic [3:0]    be;
    } wr_t;

    wr_t sb[$];
    int  total = 0;
    int  bad = 0;
    int  nwr = 0;

    always #5 clk = ~clk;

    uart_prog_loader #(
        .CLKS_PER_BIT(CPB),
        .MEM_AW      (AW),
        .MAX_WORDS   (MAXW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .uart_rx_i  (rx),
        .mem_req_o  (req),
        .mem_we_o   (we),
        .mem_addr_o (addr),
        .mem_wdata_o(wdata),
        .mem_be_o   (be),
        .mem_gnt_i  (gnt),
        .boot_done_o(done),
        .word_cnt_o (wcnt),
        .frame_err_o(ferr),
        .overrun_o  (ovr),
        .csum_o     (csum)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Write monitor: every granted request must match the head of the scoreboard.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n && req && gnt) begin
            nwr++;
            check("wr_expected", 64'(sb.size() != 0), 64'd1);
            check("wr_we", we, 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("wr_addr", addr, e.a);
                check("wr_data", wdata, e.d);
                check("wr_be", be, e.be);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        sb.delete();
        cycles(2);
    endtask

    task automatic check_zero_outputs();
        check("rst_req", req, 1'b0);
        check("rst_we", we, 1'b0);
        check("rst_addr", addr, '0);
        check("rst_wdata", wdata, '0);
        check("rst_be", be, '0);
        check("rst_done", done, 1'b0);
        check("rst_wcnt", wcnt, '0);
        check("rst_ferr", ferr, 1'b0);
        check("rst_ovr", ovr, 1'b0);
        check("rst_csum", csum, '0);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok = 1'b1);
        rx = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cycles(CPB);
        end
        rx = stop_ok;
        cycles(CPB);
        rx = 1'b1;
        if (!stop_ok) cycles(CPB);
    endtask

    task automatic send_word(input logic [31:0] w, input logic [AW-1:0] a, input logic expect_wr);
        if (expect_wr) sb.push_back('{a: a, d: w, be: 4'hF});
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int n = 0;
        while (!done && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(tag, done, 1'b1);
    endtask

    initial begin
        logic [31:0] w0, w1, w2;
        int          nwr_snap;
        w0 = 32'h0020_0113;
        w1 = 32'h1234_5678;
        w2 = 32'h0BAD_F00D;

        // Reset values, and an idle line with nothing received keeps loading.
        do_reset();
        check_zero_outputs();
        cycles(TO + 100);
        check("idle_no_done", done, 1'b0);

        // 1: single word.
        gnt = 1'b1;
        send_word(w0, 0, 1'b1);
        cycles(2);
        check("t1_wcnt", wcnt, 1);
        check("t1_nwr", nwr, 1);
        check("t1_sb_empty", sb.size(), 0);

        // 2: three words then idle timeout; rx ignored once done.
        do_reset();
        send_word(w0, 0, 1'b1);
        send_word(w1, 1, 1'b1);
        send_word(w2, 2, 1'b1);
        check("t2_wcnt", wcnt, 3);
        cycles(TO / 2);
        check("t2_not_early", done, 1'b0);
        wait_done("t2_done", 2 * TO);
        check("t2_wcnt_done", wcnt, 3);
`ifdef UART_PROG_LOADER_CSUM_EN
        check("t2_csum", csum, w0 + w1 + w2);
`else
        check("t2_csum", csum, 32'd0);
`endif
        nwr_snap = nwr;
        send_byte(8'h5A);
        cycles(5);
        check("t2_no_req_after_done", req, 1'b0);
        check("t2_nwr_after_done", nwr, nwr_snap);
        check("t2_sb_empty", sb.size(), 0);

        // 3: framing error byte is discarded.
        do_reset();
        send_byte(8'h55, 1'b0);
        check("t3_ferr", ferr, 1'b1);
        send_word(32'hDDCC_BBAA, 0, 1'b1);
        cycles(2);
        check("t3_wcnt", wcnt, 1);
        check("t3_sb_empty", sb.size(), 0);

        // 4: grant withheld across two words -> overrun, first word kept.
        do_reset();
        gnt = 1'b0;
        nwr_snap = nwr;
        send_word(32'h1111_2222, 0, 1'b1);
        check("t4_req_pending", req, 1'b1);
        send_word(32'h3333_4444, 0, 1'b0);
        check("t4_ovr", ovr, 1'b1);
        check("t4_wcnt_pending", wcnt, 0);
        check("t4_addr_pending", addr, 0);
        gnt = 1'b1;
        cycles(3);
        check("t4_wcnt", wcnt, 1);
        check("t4_addr", addr, 1);
        check("t4_nwr", nwr - nwr_snap, 1);
        check("t4_sb_empty", sb.size(), 0);

        // 5: six bytes -> full word plus partial flushed at timeout.
        do_reset();
        sb.push_back('{a: 0, d: 32'hDDCC_BBAA, be: 4'hF});
        sb.push_back('{a: 1, d: 32'h0000_FFEE, be: 4'b0011});
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        send_byte(8'hEE);
        send_byte(8'hFF);
        check("t5_wcnt_mid", wcnt, 1);
        wait_done("t5_done", 2 * TO);
        check("t5_wcnt", wcnt, 2);
        check("t5_sb_empty", sb.size(), 0);

        // 6: glitch yields nothing; reset mid-byte with a write pending.
        do_reset();
        rx = 1'b0;
        cycles(20);
        rx = 1'b1;
        cycles(200);
        check("t6_glitch_ferr", ferr, 1'b0);
        check("t6_glitch_wcnt", wcnt, 0);
        send_word(32'h0403_0201, 0, 1'b1);
        check("t6_wcnt", wcnt, 1);
        gnt = 1'b0;
        send_word(32'hCAFE_F00D, 1, 1'b0);
        check("t6_req_pending", req, 1'b1);
        rx = 1'b0;
        cycles(3 * CPB);
        rst_n = 1'b0;
        cycles(1);
        check_zero_outputs();
        rx = 1'b1;
        cycles(2);
        rst_n = 1'b1;
        gnt = 1'b1;
        cycles(2);
        send_word(w0, 0, 1'b1);
        cycles(2);
        check("t6_wcnt_after_rst", wcnt, 1);
        check("t6_sb_empty", sb.size(), 0);

        // 7: MAX_WORDS reached ends the load without waiting for timeout.
        do_reset();
        for (int i = 0; i < MAXW; i++) send_word(32'hA5A5_0000 + 32'(i), AW'(i), 1'b1);
        check("t7_done", done, 1'b1);
        check("t7_wcnt", wcnt, MAXW);
        check("t7_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
